// File: rtl/if_fetch.sv
// Instruction-fetch stage for an RV32I pipeline.
// Fetches each 32-bit instruction as four byte reads through a shared memory
// arbiter, assembles them little-endian and offers {pc, instruction} to decode.
// A redirect from execute abandons any partial fetch and restarts at the
// word-aligned branch target.
//
// Handshake semantics (decode side):
//   vld_o=1 means pc_o/is_o hold a complete instruction. They stay frozen for
//   as long as rdy_i=0. A transfer happens in a cycle where vld_o=1 and
//   rdy_i=1 and br_i=0, and the fetch of pc+4 starts in the next cycle.
//   br_i always wins. An instruction shown in a br_i cycle is dropped, even
//   when rdy_i=1 in that same cycle.
//   Memory side: a byte request transfers when mem_req=1 and mem_gnt=1. The
//   byte arrives on mem_din one cycle later. If mem_gnt=0, the request is
//   held on the same address until it is granted.
//
// The FSM state lives in `state`, and the issue/capture counters are in
// `ic`/`cc`. All three are plain named signals so checkers can bind to them.

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_a,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din,
  input  logic        br_i,
  input  logic [31:0] br_tgt,
  input  logic        rdy_i,
  output logic        vld_o,
  output logic [31:0] pc_o,
  output logic [31:0] is_o
);

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [2:0]      ic;        // byte requests granted so far (0..4)
  logic [2:0]      cc;        // bytes captured so far (0..4)
  logic            inflight;  // a granted byte arrives on mem_din this cycle
  logic [3:0][7:0] byte_buf;  // byte 0 sits in the least significant lane

  // The redirect target is always word aligned, so its low two bits are
  // ignored on purpose.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^br_tgt[1:0];

  // Request the next byte while fewer than four have been issued. The request
  // depends only on state, ic and pc. It is also forced low during reset, so
  // nothing is issued in the reset cycle.
  always_comb begin
    mem_req = 1'b0;
    mem_a   = 32'h0;
    if (!rst && (state == FETCH) && (ic < 3'd4)) begin
      mem_req = 1'b1;
      mem_a   = pc + {29'd0, ic};
    end
  end

  // Fetch FSM: issue and capture bytes, present the instruction, and handle
  // accept and redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ic       <= 3'd0;
      cc       <= 3'd0;
      inflight <= 1'b0;
      vld_o    <= 1'b0;
      byte_buf <= '0;
    end else if (br_i) begin
      // Any byte still in flight is discarded because inflight is cleared.
      // That includes a byte granted in this very cycle.
      state    <= FETCH;
      pc       <= {br_tgt[31:2], 2'b00};
      ic       <= 3'd0;
      cc       <= 3'd0;
      inflight <= 1'b0;
      vld_o    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_req && mem_gnt) begin
            ic       <= ic + 3'd1;
            inflight <= 1'b1;
          end else begin
            inflight <= 1'b0;
          end
          if (inflight) begin
            byte_buf[cc[1:0]] <= mem_din;
            cc                <= cc + 3'd1;
            if (cc == 3'd3) begin
              state <= VALID;
              vld_o <= 1'b1;
            end
          end
        end
        VALID: begin
          if (rdy_i) begin
            state    <= FETCH;
            pc       <= pc + 32'd4;
            ic       <= 3'd0;
            cc       <= 3'd0;
            inflight <= 1'b0;
            vld_o    <= 1'b0;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Decode sees an all-zero word (a bubble) whenever no instruction is held.
  // Both inputs to this mux are registers.
  always_comb begin
    is_o = 32'h0;
    if (vld_o) begin
      is_o = byte_buf;
    end
  end

  assign pc_o = pc;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed fetch, handshake, redirect, wrap and reset
// scenarios. Expected {pc, instruction} pairs are queued as stimulus is
// issued, and a monitor checks each instruction that decode is offered.

module tb_if_fetch;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_a;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic        br_i;
  logic [31:0] br_tgt;
  logic        rdy_i;
  logic        vld_o;
  logic [31:0] pc_o;
  logic [31:0] is_o;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_req (mem_req),
    .mem_a   (mem_a),
    .mem_gnt (mem_gnt),
    .mem_din (mem_din),
    .br_i    (br_i),
    .br_tgt  (br_tgt),
    .rdy_i   (rdy_i),
    .vld_o   (vld_o),
    .pc_o    (pc_o),
    .is_o    (is_o)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  bit          mon_en = 1'b0;
  logic        prev_vld = 1'b0;

  // Sparse byte memory. Unset addresses return a fixed pattern (addr ^ C3).
  logic [7:0]  mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hC3;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Wait for vld_o and compare the number of cycles it took. An expired
  // bound makes the count differ, so it is reported as a failure.
  task automatic wait_vld(input string name, input int max, input int want);
    int n;
    n = 0;
    while (!vld_o && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n), 64'(want));
  endtask

  // Memory responder: a granted byte is returned one cycle later. Otherwise
  // a junk byte is driven so that any stray capture shows up.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) mem_din <= mem_rd(mem_a);
    else                    mem_din <= 8'hEE;
  end

  // Monitor: pop the queue on every newly presented instruction, and check
  // that a bubble is always the all-zero word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (vld_o && !prev_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc=%h is=%h expected no output", pc_o, is_o);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_pc_is", {pc_o, is_o}, mon_exp);
        end
      end
      if (!vld_o) check("bubble_zero", 64'(is_o), 64'h0);
      prev_vld = vld_o;
    end
  end

  // Global time bound.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no end of test expected end before bound");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; mem_gnt = 1'b0; br_i = 1'b0; rdy_i = 1'b0; br_tgt = 32'h0;
    mem[32'h0] = 8'h13; mem[32'h1] = 8'h05; mem[32'h2] = 8'h10; mem[32'h3] = 8'h00;
    mem[32'h4] = 8'h93; mem[32'h5] = 8'h00; mem[32'h6] = 8'h10; mem[32'h7] = 8'h00;
    mem[32'h100] = 8'hB7; mem[32'h101] = 8'h12; mem[32'h102] = 8'h34; mem[32'h103] = 8'h56;
    repeat (2) @(negedge clk);

    // Reset state (rst still high)
    check("rst_vld", 64'(vld_o), 64'h0);
    check("rst_is",  64'(is_o),  64'h0);
    check("rst_pc",  64'(pc_o),  64'h0);
    check("rst_req", 64'(mem_req), 64'h0);
    check("rst_a",   64'(mem_a), 64'h0);
    mon_en = 1'b1;

    // T1: plain fetch with mem_gnt tied high.
    exp_q.push_back({32'h0000_0000, 32'h0010_0513});
    rst = 1'b0; mem_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t1_req",  64'(mem_req), 64'h1);
      check("t1_addr", 64'(mem_a), 64'(c));
      @(negedge clk);
    end
    check("t1_req4", 64'(mem_req), 64'h0);
    check("t1_vld4", 64'(vld_o), 64'h0);
    @(negedge clk);
    check("t1_vld5", 64'(vld_o), 64'h1);

    // T2: decode stalls for 10 cycles, then accepts.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t2_hold_vld", 64'(vld_o), 64'h1);
      check("t2_hold_pc_is", {pc_o, is_o}, {32'h0, 32'h0010_0513});
      check("t2_hold_req", 64'(mem_req), 64'h0);
    end
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    exp_q.push_back({32'h0000_0004, 32'h0010_0093});
    check("t2_acc_vld", 64'(vld_o), 64'h0);
    check("t2_acc_a",   64'(mem_a), 64'h4);
    check("t2_acc_req", 64'(mem_req), 64'h1);

    // T3: grant only on odd cycles, so each address repeats once.
    for (int k = 0; k < 8; k++) begin
      mem_gnt = (k % 2 == 1);
      check("t3_addr", 64'(mem_a), 64'(32'h4 + k / 2));
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    check("t3_req8", 64'(mem_req), 64'h0);
    check("t3_vld8", 64'(vld_o), 64'h0);
    @(negedge clk);
    check("t3_vld9", 64'(vld_o), 64'h1);

    // T4: redirect after two bytes are captured. The stale byte must be dropped.
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    check("t4_a0", 64'(mem_a), 64'h8);
    @(negedge clk);
    check("t4_a1", 64'(mem_a), 64'h9);
    @(negedge clk);
    check("t4_a2", 64'(mem_a), 64'hA);
    @(negedge clk);
    check("t4_a3", 64'(mem_a), 64'hB);
    br_i = 1'b1; br_tgt = 32'h0000_0102;
    exp_q.push_back({32'h0000_0100, 32'h5634_12B7});
    @(negedge clk);
    br_i = 1'b0;
    check("t4_redir_a", 64'(mem_a), 64'h100);
    check("t4_redir_vld", 64'(vld_o), 64'h0);
    wait_vld("t4_latency", 20, 5);

    // T5: move to pc=8, then br_i and rdy_i together. The fetch must go to
    // 0x40 and never to 0xC.
    br_i = 1'b1; br_tgt = 32'h0000_0008;
    exp_q.push_back({32'h0000_0008, 32'hC8C9_CACB});
    @(negedge clk);
    br_i = 1'b0;
    check("t5_a8", 64'(mem_a), 64'h8);
    wait_vld("t5_latency8", 20, 5);
    br_i = 1'b1; rdy_i = 1'b1; br_tgt = 32'h0000_0040;
    exp_q.push_back({32'h0000_0040, 32'h8081_8283});
    @(negedge clk);
    br_i = 1'b0; rdy_i = 1'b0;
    check("t5_pc40", 64'(pc_o), 64'h40);
    for (int n = 0; n < 20 && !vld_o; n++) begin
      check("t5_addr_range", 64'(mem_req ? mem_a[31:2] : 30'h10), 64'h10);
      @(negedge clk);
    end
    check("t5_vld", 64'(vld_o), 64'h1);

    // T6: a fetch at the top of the address space wraps to 0, then reset
    // hits in the middle of the next fetch.
    br_i = 1'b1; br_tgt = 32'hFFFF_FFFF;
    exp_q.push_back({32'hFFFF_FFFC, 32'h3C3D_3E3F});
    @(negedge clk);
    br_i = 1'b0;
    check("t6_pc_top", 64'(pc_o), 64'hFFFF_FFFC);
    check("t6_a_top",  64'(mem_a), 64'hFFFF_FFFC);
    wait_vld("t6_latency", 20, 5);
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    check("t6_wrap_a",   64'(mem_a), 64'h0);
    check("t6_wrap_req", 64'(mem_req), 64'h1);
    check("t6_wrap_pc",  64'(pc_o), 64'h0);
    @(negedge clk);
    check("t6_a1", 64'(mem_a), 64'h1);
    @(negedge clk);
    check("t6_a2", 64'(mem_a), 64'h2);
    rst = 1'b1;
    #1;
    check("t6_rst_req", 64'(mem_req), 64'h0);
    check("t6_rst_a",   64'(mem_a), 64'h0);
    @(negedge clk);
    check("t6_rst_vld", 64'(vld_o), 64'h0);
    check("t6_rst_is",  64'(is_o), 64'h0);
    check("t6_rst_pc",  64'(pc_o), 64'h0);
    rst = 1'b0;
    exp_q.push_back({32'h0000_0000, 32'h0010_0513});
    #1;
    check("t6_restart_req", 64'(mem_req), 64'h1);
    check("t6_restart_a",   64'(mem_a), 64'h0);
    wait_vld("t6_restart_latency", 20, 5);

    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
